float2int_pipe: RTL and testbench

- Pipelined IEEE-754 single-precision to 32-bit two's-complement integer converter; the reverse direction of the existing int2float stage.
- Used after fmult and other float arithmetic to return results to the integer domain, e.g. for the FFT output path and bench round-trip checks.
- Fixed 4-cycle latency, one conversion per enabled clock.
- Valid tag and status flags travel with the data.

---
 rtl/float2int_pipe.sv | 169 ++++++++++++++++
 tb/tb_float2int_pipe.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/float2int_pipe.sv
// float2int_pipe: 4-stage IEEE-754 single to 32-bit signed integer converter.
// Stages: unpack/classify, align into integer+guard+sticky, round, saturate/sign.
module float2int_pipe #(
   parameter int          ROUND_MODE = 0,
   parameter logic [31:0] NAN_VALUE  = 32'h00000000
) (
   input  logic        clock,
   input  logic        sclr,
   input  logic        clk_en,
   input  logic        in_valid,
   input  logic [31:0] dataa,
   output logic        out_valid,
   output logic [31:0] result,
   output logic        nan,
   output logic        overflow,
   output logic        underflow,
   output logic        zero
);

   logic        r_s1Valid;
   logic        r_s1Sign;
   logic [7:0]  r_s1Exp;
   logic [23:0] r_s1Mant;
   logic        r_s1Nan;
   logic        r_s1Inf;
   logic        r_s1Zero;

   logic        r_s2Valid;
   logic        r_s2Sign;
   logic [31:0] r_s2Int;
   logic        r_s2Guard;
   logic        r_s2Sticky;
   logic        r_s2Oor;
   logic        r_s2Nan;
   logic        r_s2Inf;
   logic        r_s2Zero;

   logic        r_s3Valid;
   logic        r_s3Sign;
   logic [32:0] r_s3Mag;
   logic        r_s3Oor;
   logic        r_s3Nan;
   logic        r_s3Inf;
   logic        r_s3Zero;

   logic signed [9:0] w_e;
   logic [4:0]  w_shl;
   logic [4:0]  w_shr;
   logic [47:0] w_wide;
   logic [31:0] w_int;
   logic        w_guard;
   logic        w_sticky;
   logic        w_oor;

   logic        w_inc;
   logic [32:0] w_mag;
   logic        w_rangeOor;

   logic [31:0] w_res;
   logic        w_nanF;
   logic        w_ovfF;
   logic        w_udfF;

   assign w_e = $signed({2'b00, r_s1Exp}) - 10'sd127;

   // Exponents 0..22 shift the mantissa right; the 48-bit window keeps the
   // dropped bits so guard (first dropped) and sticky (rest) fall out directly.
   always_comb begin
      w_shl    = 5'd0;
      w_shr    = 5'd0;
      w_wide   = 48'd0;
      w_int    = 32'd0;
      w_guard  = 1'b0;
      w_sticky = 1'b0;
      w_oor    = 1'b0;
      if (r_s1Zero || r_s1Nan || r_s1Inf) begin
         w_int = 32'd0;
      end else if (w_e >= 10'sd31) begin
         w_oor = !(r_s1Sign && (w_e == 10'sd31) && (r_s1Mant[22:0] == 23'd0));
         w_int = 32'h80000000;
      end else if (w_e >= 10'sd23) begin
         w_shl = w_e[4:0] - 5'd23;
         w_int = {8'd0, r_s1Mant} << w_shl;
      end else if (w_e >= 10'sd0) begin
         w_shr    = 5'd23 - w_e[4:0];
         w_wide   = {r_s1Mant, 24'd0} >> w_shr;
         w_int    = {8'd0, w_wide[47:24]};
         w_guard  = w_wide[23];
         w_sticky = |w_wide[22:0];
      end else if (w_e == -10'sd1) begin
         w_guard  = 1'b1;
         w_sticky = |r_s1Mant[22:0];
      end else begin
         w_sticky = 1'b1;
      end
   end

   always_comb begin
      w_inc      = (ROUND_MODE == 0) && r_s2Guard && (r_s2Sticky || r_s2Int[0]);
      w_mag      = {1'b0, r_s2Int} + {32'd0, w_inc};
      w_rangeOor = r_s2Sign ? (w_mag > 33'h080000000) : (w_mag > 33'h07FFFFFFF);
   end

   // NaN wins over saturation, so the three status flags never overlap.
   always_comb begin
      w_nanF = 1'b0;
      w_ovfF = 1'b0;
      w_udfF = 1'b0;
      w_res  = 32'd0;
      if (r_s3Nan) begin
         w_res  = NAN_VALUE;
         w_nanF = 1'b1;
      end else if (r_s3Inf || r_s3Oor || r_s3Mag[32]) begin
         w_res  = r_s3Sign ? 32'h80000000 : 32'h7FFFFFFF;
         w_ovfF = 1'b1;
      end else begin
         w_res  = r_s3Sign ? (32'd0 - r_s3Mag[31:0]) : r_s3Mag[31:0];
         w_udfF = !r_s3Zero && (w_res == 32'd0);
      end
   end

   always_ff @(posedge clock) begin
      if (sclr) begin
         r_s1Valid <= 1'b0;
         r_s2Valid <= 1'b0;
         r_s3Valid <= 1'b0;
         out_valid <= 1'b0;
         result    <= 32'd0;
         nan       <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
         zero      <= 1'b0;
      end else if (clk_en) begin
         r_s1Valid  <= in_valid;
         r_s1Sign   <= dataa[31];
         r_s1Exp    <= dataa[30:23];
         r_s1Mant   <= {1'b1, dataa[22:0]};
         r_s1Nan    <= (dataa[30:23] == 8'hFF) && (dataa[22:0] != 23'd0);
         r_s1Inf    <= (dataa[30:23] == 8'hFF) && (dataa[22:0] == 23'd0);
         r_s1Zero   <= (dataa[30:23] == 8'h00);

         r_s2Valid  <= r_s1Valid;
         r_s2Sign   <= r_s1Sign;
         r_s2Int    <= w_int;
         r_s2Guard  <= w_guard;
         r_s2Sticky <= w_sticky;
         r_s2Oor    <= w_oor;
         r_s2Nan    <= r_s1Nan;
         r_s2Inf    <= r_s1Inf;
         r_s2Zero   <= r_s1Zero;

         r_s3Valid  <= r_s2Valid;
         r_s3Sign   <= r_s2Sign;
         r_s3Mag    <= w_mag;
         r_s3Oor    <= r_s2Oor || w_rangeOor;
         r_s3Nan    <= r_s2Nan;
         r_s3Inf    <= r_s2Inf;
         r_s3Zero   <= r_s2Zero;

         out_valid  <= r_s3Valid;
         result     <= w_res;
         nan        <= r_s3Valid && w_nanF;
         overflow   <= r_s3Valid && w_ovfF;
         underflow  <= r_s3Valid && w_udfF;
         zero       <= r_s3Valid && !w_nanF && (w_res == 32'd0);
      end
   end

endmodule

// File: tb/tb_float2int_pipe.sv
// Directed bench for float2int_pipe: one instance rounding to nearest-even,
// one truncating, both fed from the same stimulus.
module tb_float2int_pipe;

   logic        clock = 1'b0;
   logic        sclr;
   logic        clk_en;
   logic        in_valid;
   logic [31:0] dataa;

   logic        outValid0, nan0, overflow0, underflow0, zero0;
   logic [31:0] result0;
   logic        outValid1, nan1, overflow1, underflow1, zero1;
   logic [31:0] result1;

   int testsRun    = 0;
   int testsFailed = 0;

   float2int_pipe #(.ROUND_MODE(0), .NAN_VALUE(32'h00000000)) dut0 (
      .clock(clock), .sclr(sclr), .clk_en(clk_en), .in_valid(in_valid), .dataa(dataa),
      .out_valid(outValid0), .result(result0), .nan(nan0), .overflow(overflow0),
      .underflow(underflow0), .zero(zero0)
   );

   float2int_pipe #(.ROUND_MODE(1), .NAN_VALUE(32'h00000000)) dut1 (
      .clock(clock), .sclr(sclr), .clk_en(clk_en), .in_valid(in_valid), .dataa(dataa),
      .out_valid(outValid1), .result(result1), .nan(nan1), .overflow(overflow1),
      .underflow(underflow1), .zero(zero1)
   );

   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Exact float encoding of a nonnegative integer below 2^24.
   function automatic logic [31:0] toFloat(input int unsigned v);
      int          p;
      logic [31:0] m;
      if (v == 0) return 32'h00000000;
      p = 0;
      for (int b = 0; b < 32; b++) if (v[b]) p = b;
      m = v << (23 - p);
      return {1'b0, 8'(127 + p), m[22:0]};
   endfunction

   // Present one word, then let three more edges pass with bubbles behind it.
   task automatic pushAndWait3(input logic [31:0] v);
      in_valid = 1'b1;
      dataa    = v;
      step();
      in_valid = 1'b0;
      dataa    = 32'hDEADBEEF;
      step();
      step();
   endtask

   task automatic test_reset();
      sclr = 1'b1; clk_en = 1'b1; in_valid = 1'b0; dataa = 32'd0;
      step();
      step();
      testsRun++;
      if ({outValid0, result0, nan0, overflow0, underflow0, zero0} !== 37'd0) begin
         testsFailed++;
         $display("[TB] FAIL reset_dut0: got v=%b r=%h f=%b%b%b%b want all 0",
                  outValid0, result0, nan0, overflow0, underflow0, zero0);
      end
      testsRun++;
      if ({outValid1, result1, nan1, overflow1, underflow1, zero1} !== 37'd0) begin
         testsFailed++;
         $display("[TB] FAIL reset_dut1: got v=%b r=%h f=%b%b%b%b want all 0",
                  outValid1, result1, nan1, overflow1, underflow1, zero1);
      end
      sclr = 1'b0;
      step();
   endtask

   // Flag order in the tables: {nan, overflow, underflow, zero}.
   task automatic test_basic();
      logic [31:0] vIn  [5] = '{32'h3F800000, 32'h40200000, 32'h40600000, 32'hC0200000, 32'h3F000001};
      logic [31:0] vOut [5] = '{32'h00000001, 32'h00000002, 32'h00000004, 32'hFFFFFFFE, 32'h00000001};
      for (int i = 0; i < 5; i++) begin
         pushAndWait3(vIn[i]);
         testsRun++;
         if (outValid0 !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL basic_early_%h: out_valid=%b after 3 edges, want 0", vIn[i], outValid0);
         end
         step();
         testsRun++;
         if ({outValid0, result0, nan0, overflow0, underflow0, zero0} !== {1'b1, vOut[i], 4'b0000}) begin
            testsFailed++;
            $display("[TB] FAIL basic_%h: got v=%b r=%h f=%b%b%b%b want v=1 r=%h f=0000",
                     vIn[i], outValid0, result0, nan0, overflow0, underflow0, zero0, vOut[i]);
         end
      end
   endtask

   task automatic test_limits();
      logic [31:0] vIn  [4] = '{32'h4F000000, 32'hCF000000, 32'hFF800000, 32'h7F800000};
      logic [31:0] vOut [4] = '{32'h7FFFFFFF, 32'h80000000, 32'h80000000, 32'h7FFFFFFF};
      logic [3:0]  vFlg [4] = '{4'b0100, 4'b0000, 4'b0100, 4'b0100};
      for (int i = 0; i < 4; i++) begin
         pushAndWait3(vIn[i]);
         step();
         testsRun++;
         if ({outValid0, result0, nan0, overflow0, underflow0, zero0} !== {1'b1, vOut[i], vFlg[i]}) begin
            testsFailed++;
            $display("[TB] FAIL limits_%h: got v=%b r=%h f=%b%b%b%b want v=1 r=%h f=%b",
                     vIn[i], outValid0, result0, nan0, overflow0, underflow0, zero0, vOut[i], vFlg[i]);
         end
      end
   endtask

   task automatic test_specials();
      logic [31:0] vIn  [5] = '{32'h7FC00000, 32'h3F000000, 32'h00000001, 32'h00000000, 32'h80000000};
      logic [3:0]  vFlg [5] = '{4'b1000, 4'b0011, 4'b0001, 4'b0001, 4'b0001};
      for (int i = 0; i < 5; i++) begin
         pushAndWait3(vIn[i]);
         step();
         testsRun++;
         if ({outValid0, result0, nan0, overflow0, underflow0, zero0} !== {1'b1, 32'd0, vFlg[i]}) begin
            testsFailed++;
            $display("[TB] FAIL specials_%h: got v=%b r=%h f=%b%b%b%b want v=1 r=00000000 f=%b",
                     vIn[i], outValid0, result0, nan0, overflow0, underflow0, zero0, vFlg[i]);
         end
      end
   endtask

   task automatic test_truncate();
      logic [31:0] vIn   [4] = '{32'h40600000, 32'hBFF00000, 32'h40200000, 32'h3F000000};
      logic [31:0] vOut1 [4] = '{32'h00000003, 32'hFFFFFFFF, 32'h00000002, 32'h00000000};
      logic [3:0]  vFlg1 [4] = '{4'b0000, 4'b0000, 4'b0000, 4'b0011};
      logic [31:0] vOut0 [4] = '{32'h00000004, 32'hFFFFFFFE, 32'h00000002, 32'h00000000};
      for (int i = 0; i < 4; i++) begin
         pushAndWait3(vIn[i]);
         step();
         testsRun++;
         if ({outValid1, result1, nan1, overflow1, underflow1, zero1} !== {1'b1, vOut1[i], vFlg1[i]}) begin
            testsFailed++;
            $display("[TB] FAIL truncate_%h: got v=%b r=%h f=%b%b%b%b want v=1 r=%h f=%b",
                     vIn[i], outValid1, result1, nan1, overflow1, underflow1, zero1, vOut1[i], vFlg1[i]);
         end
         testsRun++;
         if (result0 !== vOut0[i]) begin
            testsFailed++;
            $display("[TB] FAIL nearest_vs_trunc_%h: got r=%h want %h", vIn[i], result0, vOut0[i]);
         end
      end
   endtask

   // Eight words with clk_en low for three cycles in the middle; a 4-deep
   // delay model advances only on enabled edges.
   task automatic test_stall();
      logic        mV [4];
      logic [31:0] mD [4];
      logic        en;
      int          sent;
      int          got;
      sent = 0;
      got  = 0;
      for (int k = 0; k < 4; k++) begin mV[k] = 1'b0; mD[k] = 32'd0; end
      for (int c = 0; c < 16; c++) begin
         en       = !(c >= 4 && c < 7);
         clk_en   = en;
         in_valid = (sent < 8);
         dataa    = toFloat(sent + 1);
         @(posedge clock);
         if (en) begin
            for (int k = 3; k > 0; k--) begin mV[k] = mV[k-1]; mD[k] = mD[k-1]; end
            mV[0] = in_valid;
            mD[0] = sent + 1;
            if (in_valid) sent++;
         end
         #1;
         testsRun++;
         if (outValid0 !== mV[3] || (mV[3] && result0 !== mD[3])) begin
            testsFailed++;
            $display("[TB] FAIL stall_cycle%0d: got v=%b r=%h want v=%b r=%h",
                     c, outValid0, result0, mV[3], mD[3]);
         end
         if (en && outValid0 === 1'b1) got++;
      end
      clk_en   = 1'b1;
      in_valid = 1'b0;
      testsRun++;
      if (got !== 8) begin
         testsFailed++;
         $display("[TB] FAIL stall_count: got %0d results want 8", got);
      end
   endtask

   task automatic test_sclr();
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         dataa = toFloat(i + 10);
         step();
      end
      in_valid = 1'b0;
      clk_en   = 1'b0;
      sclr     = 1'b1;
      step();
      sclr   = 1'b0;
      clk_en = 1'b1;
      testsRun++;
      if ({outValid0, result0, nan0, overflow0, underflow0, zero0} !== 37'd0) begin
         testsFailed++;
         $display("[TB] FAIL sclr_clear: got v=%b r=%h f=%b%b%b%b want all 0",
                  outValid0, result0, nan0, overflow0, underflow0, zero0);
      end
      for (int i = 0; i < 4; i++) begin
         step();
         testsRun++;
         if (outValid0 !== 1'b0 || outValid1 !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL sclr_flush%0d: got v0=%b v1=%b want 0", i, outValid0, outValid1);
         end
      end
   endtask

   // Counter values (plus a sparse sweep up to 16e6) encoded as floats must
   // come back unchanged four cycles later.
   task automatic test_round_trip();
      logic        mV [4];
      logic [31:0] mD [4];
      int unsigned v;
      for (int k = 0; k < 4; k++) begin mV[k] = 1'b0; mD[k] = 32'd0; end
      clk_en = 1'b1;
      for (int c = 0; c < 3025; c++) begin
         v        = (c <= 3000) ? c : (c - 3000) * 800000;
         in_valid = (c < 3021);
         dataa    = toFloat(v);
         @(posedge clock);
         for (int k = 3; k > 0; k--) begin mV[k] = mV[k-1]; mD[k] = mD[k-1]; end
         mV[0] = in_valid;
         mD[0] = v;
         #1;
         testsRun++;
         if (outValid0 !== mV[3] ||
             (mV[3] && {result0, nan0, overflow0, underflow0, zero0} !==
                       {mD[3], 3'b000, (mD[3] == 32'd0)})) begin
            testsFailed++;
            $display("[TB] FAIL round_trip_cycle%0d: got v=%b r=%h f=%b%b%b%b want v=%b r=%h",
                     c, outValid0, result0, nan0, overflow0, underflow0, zero0, mV[3], mD[3]);
         end
      end
      in_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_limits();
      test_specials();
      test_truncate();
      test_stall();
      test_sclr();
      test_round_trip();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
